// File: rtl/program_loader_if.sv
// Boundary bundle of the program loader: byte stream in, instruction RAM writes
// and CPU control out. dbg_state mirrors the loader FSM for checkers.
interface program_loader_if;
    // A byte moves on a rising clk edge where rx_valid && rx_ready; the sender keeps
    // rx_data stable while rx_valid is high and not yet accepted, and rx_ready never
    // depends combinationally on rx_valid.
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  dbg_state;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, error, dbg_state
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, error, dbg_state
    );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, checksummed word stream into the 2048x16 instruction RAM
// and releases the CPU from reset only after a clean load.
module program_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, LEN_H, LEN_L, DATA_H, DATA_L, WRITE, CSUM, DONE, ERR
    } state_t;

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [11:0]       addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        csum_q, csum_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    logic        rx_ready;
    logic        accept;
    logic [15:0] len_full;
    logic [11:0] addr_next;

    assign rx_ready  = (state_q == LEN_H) || (state_q == LEN_L) || (state_q == DATA_H) ||
                       (state_q == DATA_L) || (state_q == CSUM);
    assign accept    = bus.rx_valid && rx_ready;
    assign len_full  = {len_q[15:8], bus.rx_data};
    assign addr_next = addr_q + 12'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        csum_d  = csum_q;
        idle_d  = idle_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    state_d = LEN_H;
                    addr_d  = 12'd0;
                    csum_d  = 8'd0;
                    idle_d  = '0;
                end
            end
            LEN_H: begin
                if (accept) begin
                    len_d[15:8] = bus.rx_data;
                    state_d     = LEN_L;
                end
            end
            LEN_L: begin
                if (accept) begin
                    len_d   = len_full;
                    state_d = (len_full == 16'd0 || len_full > 16'd2048) ? ERR : DATA_H;
                end
            end
            DATA_H: begin
                if (accept) begin
                    hi_d    = bus.rx_data;
                    csum_d  = csum_q + bus.rx_data;
                    state_d = DATA_L;
                end
            end
            DATA_L: begin
                if (accept) begin
                    lo_d    = bus.rx_data;
                    csum_d  = csum_q + bus.rx_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // 12-bit counter so a full 2048-word image ends at 2048 instead of wrapping.
                addr_d  = addr_next;
                state_d = ({4'd0, addr_next} < len_q) ? DATA_H : CSUM;
            end
            CSUM: begin
                if (accept) begin
                    state_d = (bus.rx_data == csum_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stall watchdog: only ticks while waiting for a byte.
        if (rx_ready) begin
            if (accept) begin
                idle_d = '0;
            end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = ERR;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= 16'd0;
            addr_q  <= 12'd0;
            hi_q    <= 8'd0;
            lo_q    <= 8'd0;
            csum_q  <= 8'd0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            csum_q  <= csum_d;
            idle_q  <= idle_d;
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.mem_we    = (state_q == WRITE);
    assign bus.mem_addr  = addr_q[10:0];
    assign bus.mem_wdata = {hi_q, lo_q};
    assign bus.cpu_rst   = (state_q != DONE);
    assign bus.busy      = rx_ready || (state_q == WRITE);
    assign bus.done      = (state_q == DONE);
    assign bus.error     = (state_q == ERR);
    assign bus.dbg_state = state_q;
endmodule
